mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sole owner of the CPU's byte-wide RAM/IO port.
- Shares the port between three requesters: instruction fetch (word reads), LSB loads (B/H/W reads with extension) and ROB store commits (B/H/W writes).
- Sequences multi-byte transfers, holds IO stores while the UART buffer is full, and drops speculative reads on flush.
- busy_out drives the ROB's mem_busy input; the load result port drives the ROB/RS mem_valid/mem_dependency/mem_value bus.

Parameters:
- DEP_W, 6, width of the ROB dependency tag (ROB_SIZE_WIDTH+1).
- IO_ADDR_BIT, 17, an address is IO when bits [IO_ADDR_BIT:IO_ADDR_BIT-1] == 2'b11 (0x30000 region).

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global enable; low freezes all state
- flush_in  in  1  mispredict flush from ROB
- io_buffer_full_in  in  1  UART buffer full
- mem_din  in  8  RAM read byte; valid one cycle after mem_a
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write
- if_req  in  1  level; fetch request, held until if_valid_out
- if_addr  in  32  fetch address
- if_valid_out  out  1  one-cycle pulse
- if_data_out  out  32  fetched word, little-endian
- ld_req  in  1  level; held until ld_valid_out
- ld_addr  in  32  load address
- ld_type  in  3  LB=000 LH=001 LW=010 LBU=100 LHU=101
- ld_dep  in  DEP_W  ROB tag of the load
- ld_valid_out  out  1  one-cycle pulse
- ld_value_out  out  32  extended load result
- ld_dep_out  out  DEP_W  tag echoed with the result
- st_req  in  1  single-cycle pulse from ROB commit
- st_addr  in  32  store address
- st_type  in  2  SB=00 SH=01 SW=10
- st_data  in  32  store data
- st_done_out  out  1  pulse after the last byte is written
- busy_out  out  1  high when state != IDLE or a store is pending

Behaviour:
- Reset (async, rst_n_in low):
  - state = IDLE; all outputs 0; pending-store slot empty.
  - Reset mid-transfer abandons the transfer immediately.
- rdy_in low: state, counters and outputs hold.
- Byte count N: 1/2/4 for B/H/W; fetch is always 4.
- States: IDLE, RD, WR, WAIT_IO.
- Pending-store slot (one entry): any st_req pulse is captured in this slot in the cycle it arrives, in every state. It is cleared when the store is granted.
- Grant in IDLE, priority order:
  - pending store or same-cycle st_req;
  - then ld_req;
  - then if_req.
- RD:
  - The address for byte k is presented at edge T+k, k = 0..N-1.
  - The byte is captured into the assembly register at edge T+k+2, i.e. one cycle after mem_a is visible.
  - The valid pulse is registered at edge T+N+1.
  - Accept-to-valid latency is N+2 cycles; IDLE is re-entered on the same edge.
- Load result:
  - Signed types sign-extend bit 8N-1; unsigned types zero-extend.
  - ld_dep_out is the latched ld_dep.
- WR:
  - mem_wr=1 with mem_a=addr+k and mem_dout=data[8k+7:8k] for N consecutive cycles.
  - st_done_out pulses the cycle after the last byte; then return to IDLE.
- WAIT_IO: a granted store to an IO address while io_buffer_full_in=1 enters WAIT_IO with mem_wr=0. It moves to WR on the first cycle io_buffer_full_in=0.
- Flush (flush_in high at an edge):
  - RD aborts to IDLE; no valid pulse; fetch/load grants that edge are suppressed.
  - WR, WAIT_IO and the pending slot are unaffected; committed stores always complete.
- Address arithmetic wraps modulo 2^32.
- mem_wr is 0 in every state except WR.

Optional Feature:
- MEM_ARB_RR_EN defined: fetch vs load arbitration is round-robin. A last-granted bit alternates when both are requesting; the store still has top priority.
- Undefined: load always beats fetch.

Decomposition:
- Shared package/const_param additions:
  - load/store type encodings;
  - arbiter state encoding;
  - IO region constant.
- Sub-module load_extender (combinational): takes the assembled bytes and ld_type, and produces the 32-bit extended value.

Test Plan:
- Fetch 0x1000, RAM bytes 13,00,50,00 -> if_valid_out 6 cycles after accept, if_data_out=0x00500013, mem_wr never 1.
- LB 0x2003 (byte 0x80), ld_dep=5 -> ld_value_out=0xFFFFFF80, ld_dep_out=5. Same with LBU -> 0x00000080.
- SW 0x100, data 0xDEADBEEF -> mem_wr=1 for 4 cycles, mem_a 0x100..0x103, mem_dout EF,BE,AD,DE; st_done_out pulse once.
- SB to 0x30000 with io_buffer_full_in high 3 cycles -> no mem_wr for those cycles, then one write of the byte, then st_done_out.
- Flush during fetch byte 2 -> no if_valid_out, busy_out low next cycle. Flush during SW -> all 4 bytes still written.
- st_req pulse mid-fetch with ld_req also pending -> fetch completes, store serviced next, then load. Under MEM_ARB_RR_EN, back-to-back if_req/ld_req alternate grants.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-wide memory port arbiter: state, access types,
// IO region and the access-size helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD      = 2'd1,
        S_WR      = 2'd2,
        S_WAIT_IO = 2'd3
    } arb_state_e;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    localparam logic [1:0] IO_REGION = 2'b11;

    // Low two type bits encode the size for both loads and stores.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            ST_SB:   return 3'd1;
            ST_SH:   return 3'd2;
            ST_SW:   return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_load_extender.sv
// Combinational sign/zero extension of assembled load bytes by load type.
module mem_arbiter_load_extender
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] bytes_in,
    input  logic [2:0]  ld_type,
    output logic [31:0] value_out
);

    always_comb begin
        value_out = bytes_in;
        case (ld_type)
            LD_LB:   value_out = {{24{bytes_in[7]}}, bytes_in[7:0]};
            LD_LH:   value_out = {{16{bytes_in[15]}}, bytes_in[15:0]};
            LD_LW:   value_out = bytes_in;
            LD_LBU:  value_out = {24'd0, bytes_in[7:0]};
            LD_LHU:  value_out = {16'd0, bytes_in[15:0]};
            default: value_out = bytes_in;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO port arbiter for instruction fetch, LSB loads and ROB store commits.
// Build option MEM_ARB_RR_EN: fetch/load round-robin instead of load-first.
//
//  state     | meaning
//  S_IDLE    | port free; grant store > load > fetch
//  S_RD      | issuing/capturing read bytes for fetch or load
//  S_WR      | writing store bytes, one per cycle
//  S_WAIT_IO | IO store parked until the UART buffer has room
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DEP_W       = 6,
    parameter int IO_ADDR_BIT = 17
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             io_buffer_full_in,
    input  logic [7:0]       mem_din,
    output logic [7:0]       mem_dout,
    output logic [31:0]      mem_a,
    output logic             mem_wr,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_valid_out,
    output logic [31:0]      if_data_out,
    input  logic             ld_req,
    input  logic [31:0]      ld_addr,
    input  logic [2:0]       ld_type,
    input  logic [DEP_W-1:0] ld_dep,
    output logic             ld_valid_out,
    output logic [31:0]      ld_value_out,
    output logic [DEP_W-1:0] ld_dep_out,
    input  logic             st_req,
    input  logic [31:0]      st_addr,
    input  logic [1:0]       st_type,
    input  logic [31:0]      st_data,
    output logic             st_done_out,
    output logic             busy_out
);

    arb_state_e       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       nbytes_q, nbytes_d;
    logic             is_ld_q, is_ld_d;
    logic [31:0]      addr_q, addr_d;
    logic [2:0]       ld_type_q, ld_type_d;
    logic [DEP_W-1:0] dep_q, dep_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      asm_q, asm_d;
    logic             slot_vld_q, slot_vld_d;
    logic [31:0]      slot_addr_q, slot_addr_d;
    logic [1:0]       slot_type_q, slot_type_d;
    logic [31:0]      slot_data_q, slot_data_d;
    logic [31:0]      mem_a_q, mem_a_d;
    logic [7:0]       mem_dout_q, mem_dout_d;
    logic             mem_wr_q, mem_wr_d;
    logic             if_valid_q, if_valid_d;
    logic [31:0]      if_data_q, if_data_d;
    logic             ld_valid_q, ld_valid_d;
    logic [31:0]      ld_value_q, ld_value_d;
    logic             st_done_q, st_done_d;
`ifdef MEM_ARB_RR_EN
    logic             last_ld_q, last_ld_d;
`endif

    logic [31:0] s_addr;
    logic [1:0]  s_type;
    logic [31:0] s_data;
    logic        st_grant;
    logic        pick_ld;
    logic [2:0]  cnt_inc;
    logic [1:0]  cap_idx;
    logic [31:0] asm_next;
    logic [31:0] ext_value;

    function automatic logic is_io(input logic [31:0] a);
        return a[IO_ADDR_BIT -: 2] == IO_REGION;
    endfunction

    // A parked store always wins over one arriving in the same cycle.
    assign s_addr = slot_vld_q ? slot_addr_q : st_addr;
    assign s_type = slot_vld_q ? slot_type_q : st_type;
    assign s_data = slot_vld_q ? slot_data_q : st_data;

`ifdef MEM_ARB_RR_EN
    assign pick_ld = ld_req && !(if_req && last_ld_q);
`else
    assign pick_ld = ld_req;
`endif

    assign cnt_inc = cnt_q + 3'd1;
    assign cap_idx = cnt_q[1:0] - 2'd1;

    // mem_din carries byte cnt_q-1 during RD cycle cnt_q.
    always_comb begin
        asm_next = asm_q;
        if (cnt_q != 3'd0) begin
            asm_next[{cap_idx, 3'b000} +: 8] = mem_din;
        end
    end

    mem_arbiter_load_extender u_load_extender (
        .bytes_in  (asm_next),
        .ld_type   (ld_type_q),
        .value_out (ext_value)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbytes_d    = nbytes_q;
        is_ld_d     = is_ld_q;
        addr_d      = addr_q;
        ld_type_d   = ld_type_q;
        dep_d       = dep_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        slot_vld_d  = slot_vld_q;
        slot_addr_d = slot_addr_q;
        slot_type_d = slot_type_q;
        slot_data_d = slot_data_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = 1'b0;
        if_valid_d  = 1'b0;
        if_data_d   = if_data_q;
        ld_valid_d  = 1'b0;
        ld_value_d  = ld_value_q;
        st_done_d   = 1'b0;
        st_grant    = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_ld_d   = last_ld_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (slot_vld_q || st_req) begin
                    st_grant = 1'b1;
                    addr_d   = s_addr;
                    wdata_d  = s_data;
                    nbytes_d = size_to_nbytes(s_type);
                    cnt_d    = 3'd0;
                    if (is_io(s_addr) && io_buffer_full_in) begin
                        state_d = S_WAIT_IO;
                    end else begin
                        state_d    = S_WR;
                        mem_wr_d   = 1'b1;
                        mem_a_d    = s_addr;
                        mem_dout_d = s_data[7:0];
                    end
                end else if (!flush_in && (ld_req || if_req)) begin
                    state_d = S_RD;
                    cnt_d   = 3'd0;
                    asm_d   = '0;
                    is_ld_d = pick_ld;
`ifdef MEM_ARB_RR_EN
                    last_ld_d = pick_ld;
`endif
                    if (pick_ld) begin
                        addr_d    = ld_addr;
                        mem_a_d   = ld_addr;
                        nbytes_d  = size_to_nbytes(ld_type[1:0]);
                        ld_type_d = ld_type;
                        dep_d     = ld_dep;
                    end else begin
                        addr_d   = if_addr;
                        mem_a_d  = if_addr;
                        nbytes_d = 3'd4;
                    end
                end
            end

            S_RD: begin
                if (flush_in) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    asm_d = asm_next;
                    if (cnt_q == nbytes_q) begin
                        state_d = S_IDLE;
                        cnt_d   = 3'd0;
                        if (is_ld_q) begin
                            ld_valid_d = 1'b1;
                            ld_value_d = ext_value;
                        end else begin
                            if_valid_d = 1'b1;
                            if_data_d  = asm_next;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc < nbytes_q) begin
                            mem_a_d = addr_q + {29'd0, cnt_inc};
                        end
                    end
                end
            end

            S_WR: begin
                if (cnt_inc < nbytes_q) begin
                    mem_wr_d   = 1'b1;
                    mem_a_d    = addr_q + {29'd0, cnt_inc};
                    mem_dout_d = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
                    cnt_d      = cnt_inc;
                end else begin
                    state_d   = S_IDLE;
                    st_done_d = 1'b1;
                    cnt_d     = 3'd0;
                end
            end

            S_WAIT_IO: begin
                if (!io_buffer_full_in) begin
                    state_d    = S_WR;
                    mem_wr_d   = 1'b1;
                    mem_a_d    = addr_q;
                    mem_dout_d = wdata_q[7:0];
                    cnt_d      = 3'd0;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (st_grant && slot_vld_q) begin
            slot_vld_d = 1'b0;
        end
        // Capture unless this very pulse was granted straight from IDLE.
        if (st_req && !(st_grant && !slot_vld_q)) begin
            slot_vld_d  = 1'b1;
            slot_addr_d = st_addr;
            slot_type_d = st_type;
            slot_data_d = st_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            nbytes_q    <= '0;
            is_ld_q     <= 1'b0;
            addr_q      <= '0;
            ld_type_q   <= '0;
            dep_q       <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            slot_vld_q  <= 1'b0;
            slot_addr_q <= '0;
            slot_type_q <= '0;
            slot_data_q <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            if_data_q   <= '0;
            ld_valid_q  <= 1'b0;
            ld_value_q  <= '0;
            st_done_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_ld_q   <= 1'b0;
`endif
        end else if (rdy_in) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nbytes_q    <= nbytes_d;
            is_ld_q     <= is_ld_d;
            addr_q      <= addr_d;
            ld_type_q   <= ld_type_d;
            dep_q       <= dep_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            slot_vld_q  <= slot_vld_d;
            slot_addr_q <= slot_addr_d;
            slot_type_q <= slot_type_d;
            slot_data_q <= slot_data_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            if_valid_q  <= if_valid_d;
            if_data_q   <= if_data_d;
            ld_valid_q  <= ld_valid_d;
            ld_value_q  <= ld_value_d;
            st_done_q   <= st_done_d;
`ifdef MEM_ARB_RR_EN
            last_ld_q   <= last_ld_d;
`endif
        end
    end

    assign mem_a        = mem_a_q;
    assign mem_dout     = mem_dout_q;
    assign mem_wr       = mem_wr_q;
    assign if_valid_out = if_valid_q;
    assign if_data_out  = if_data_q;
    assign ld_valid_out = ld_valid_q;
    assign ld_value_out = ld_value_q;
    assign ld_dep_out   = dep_q;
    assign st_done_out  = st_done_q;
    assign busy_out     = (state_q != S_IDLE) || slot_vld_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a one-cycle-latency byte RAM.
module tb_mem_arbiter;

    localparam int DEP_W = 6;

    localparam logic [31:0] LT_ADDR [5] = '{32'h2003, 32'h2003, 32'h2004, 32'h2004, 32'h2008};
    localparam logic [2:0]  LT_TYPE [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    localparam logic [31:0] LT_EXP  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF9234,
                                            32'h00009234, 32'h12345678};
    localparam int          LT_LAT  [5] = '{3, 3, 4, 4, 6};
    localparam logic [7:0]  SW_BYTES [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    localparam logic [7:0]  FL_BYTES [4] = '{8'h44, 8'h33, 8'h22, 8'h11};

    logic             clk_in = 1'b0;
    logic             rst_n_in = 1'b0;
    logic             rdy_in = 1'b1;
    logic             flush_in = 1'b0;
    logic             io_buffer_full_in = 1'b0;
    logic [7:0]       mem_din = 8'h00;
    logic [7:0]       mem_dout;
    logic [31:0]      mem_a;
    logic             mem_wr;
    logic             if_req = 1'b0;
    logic [31:0]      if_addr = '0;
    logic             if_valid_out;
    logic [31:0]      if_data_out;
    logic             ld_req = 1'b0;
    logic [31:0]      ld_addr = '0;
    logic [2:0]       ld_type = '0;
    logic [DEP_W-1:0] ld_dep = '0;
    logic             ld_valid_out;
    logic [31:0]      ld_value_out;
    logic [DEP_W-1:0] ld_dep_out;
    logic             st_req = 1'b0;
    logic [31:0]      st_addr = '0;
    logic [1:0]       st_type = '0;
    logic [31:0]      st_data = '0;
    logic             st_done_out;
    logic             busy_out;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0]  ram [int unsigned];
    logic [31:0] prev_a = '0;

    mem_arbiter #(.DEP_W(DEP_W), .IO_ADDR_BIT(17)) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .rdy_in            (rdy_in),
        .flush_in          (flush_in),
        .io_buffer_full_in (io_buffer_full_in),
        .mem_din           (mem_din),
        .mem_dout          (mem_dout),
        .mem_a             (mem_a),
        .mem_wr            (mem_wr),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .if_valid_out      (if_valid_out),
        .if_data_out       (if_data_out),
        .ld_req            (ld_req),
        .ld_addr           (ld_addr),
        .ld_type           (ld_type),
        .ld_dep            (ld_dep),
        .ld_valid_out      (ld_valid_out),
        .ld_value_out      (ld_value_out),
        .ld_dep_out        (ld_dep_out),
        .st_req            (st_req),
        .st_addr           (st_addr),
        .st_type           (st_type),
        .st_data           (st_data),
        .st_done_out       (st_done_out),
        .busy_out          (busy_out)
    );

    always #5 clk_in = ~clk_in;

    // RAM returns the byte for the address that was on mem_a during the previous cycle.
    always @(negedge clk_in) begin
        mem_din = ram.exists(prev_a) ? ram[prev_a] : 8'h00;
        prev_a  = mem_a;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] t, input logic [DEP_W-1:0] d,
                           output int lat, output logic [31:0] v, output logic [DEP_W-1:0] dep_o);
        lat = 0; v = '0; dep_o = '0;
        ld_req = 1'b1; ld_addr = a; ld_type = t; ld_dep = d;
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            tick();
            if (ld_valid_out) begin
                lat = i; v = ld_value_out; dep_o = ld_dep_out;
            end
        end
        ld_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        #3;
        n_cmp++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        n_cmp++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
        n_cmp++; if ({if_valid_out, ld_valid_out, st_done_out, busy_out} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {if_valid_out, ld_valid_out, st_done_out, busy_out});
        end
        n_cmp++; if ({if_data_out, ld_value_out, ld_dep_out, mem_dout} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h want 0", if_data_out, ld_value_out, ld_dep_out, mem_dout);
        end
        tick(); tick();
        rst_n_in = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        int lat;
        logic seen_wr;
        logic [31:0] data;
        lat = 0; seen_wr = 1'b0; data = '0;
        if_req = 1'b1; if_addr = 32'h1000;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick();
            if (mem_wr) seen_wr = 1'b1;
            if (if_valid_out) begin lat = i; data = if_data_out; end
        end
        if_req = 1'b0;
        n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL fetch_latency: got %0d want 6", lat); end
        n_cmp++; if (data !== 32'h00500013) begin n_fail++; $display("FAIL fetch_data: got %h want 00500013", data); end
        n_cmp++; if (seen_wr !== 1'b0) begin n_fail++; $display("FAIL fetch_mem_wr: got %b want 0", seen_wr); end
        tick();
        n_cmp++; if ({if_valid_out, busy_out} !== 2'b00) begin
            n_fail++; $display("FAIL fetch_after: got %b want 00", {if_valid_out, busy_out});
        end
    endtask

    task automatic test_load_ext();
        int lat;
        logic [31:0] v;
        logic [DEP_W-1:0] dep_o;
        for (int k = 0; k < 5; k++) begin
            do_load(LT_ADDR[k], LT_TYPE[k], DEP_W'(5 + k), lat, v, dep_o);
            n_cmp++; if (v !== LT_EXP[k]) begin n_fail++; $display("FAIL load_value[%0d]: got %h want %h", k, v, LT_EXP[k]); end
            n_cmp++; if (dep_o !== DEP_W'(5 + k)) begin n_fail++; $display("FAIL load_dep[%0d]: got %0d want %0d", k, dep_o, 5 + k); end
            n_cmp++; if (lat !== LT_LAT[k]) begin n_fail++; $display("FAIL load_latency[%0d]: got %0d want %0d", k, lat, LT_LAT[k]); end
        end
        tick();
    endtask

    task automatic test_rdy_freeze();
        int lat;
        logic held;
        lat = 0; held = 1'b1;
        ld_req = 1'b1; ld_addr = 32'h2003; ld_type = 3'b000; ld_dep = 6'd7;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick();
            if (i >= 2 && i <= 4 && (mem_a !== 32'h2003 || ld_valid_out !== 1'b0)) held = 1'b0;
            if (ld_valid_out) lat = i;
            if (i == 1) rdy_in = 1'b0;
            if (i == 4) rdy_in = 1'b1;
        end
        ld_req = 1'b0;
        rdy_in = 1'b1;
        n_cmp++; if (held !== 1'b1) begin n_fail++; $display("FAIL rdy_hold: got %b want 1", held); end
        n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL rdy_latency: got %0d want 6", lat); end
        n_cmp++; if (ld_value_out !== 32'hFFFFFF80) begin n_fail++; $display("FAIL rdy_value: got %h want FFFFFF80", ld_value_out); end
        tick();
    endtask

    task automatic test_store_word();
        int done_cnt;
        done_cnt = 0;
        st_req = 1'b1; st_addr = 32'h100; st_type = 2'b10; st_data = 32'hDEADBEEF;
        tick();
        st_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h100 + 32'(k), SW_BYTES[k]}) begin
                n_fail++; $display("FAIL sw_byte[%0d]: got wr=%b a=%h d=%h want wr=1 a=%h d=%h",
                                   k, mem_wr, mem_a, mem_dout, 32'h100 + 32'(k), SW_BYTES[k]);
            end
            if (st_done_out) done_cnt++;
            tick();
        end
        n_cmp++; if ({mem_wr, st_done_out} !== 2'b01) begin
            n_fail++; $display("FAIL sw_done: got wr,done=%b want 01", {mem_wr, st_done_out});
        end
        if (st_done_out) done_cnt++;
        tick();
        if (st_done_out) done_cnt++;
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL sw_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL sw_busy_after: got %b want 0", busy_out); end
    endtask

    task automatic test_io_store();
        io_buffer_full_in = 1'b1;
        st_req = 1'b1; st_addr = 32'h30000; st_type = 2'b00; st_data = 32'h0000005A;
        tick();
        st_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            n_cmp++; if ({mem_wr, busy_out} !== 2'b01) begin
                n_fail++; $display("FAIL io_wait[%0d]: got wr,busy=%b want 01", i, {mem_wr, busy_out});
            end
        end
        io_buffer_full_in = 1'b0;
        tick();
        n_cmp++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h30000, 8'h5A}) begin
            n_fail++; $display("FAIL io_write: got wr=%b a=%h d=%h want wr=1 a=00030000 d=5a", mem_wr, mem_a, mem_dout);
        end
        tick();
        n_cmp++; if ({mem_wr, st_done_out} !== 2'b01) begin
            n_fail++; $display("FAIL io_done: got wr,done=%b want 01", {mem_wr, st_done_out});
        end
        tick();
        // 0x20000 has only the upper region bit set, so it is plain RAM.
        io_buffer_full_in = 1'b1;
        st_req = 1'b1; st_addr = 32'h20000; st_type = 2'b00; st_data = 32'h000000C3;
        tick();
        st_req = 1'b0;
        n_cmp++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h20000, 8'hC3}) begin
            n_fail++; $display("FAIL nonio_write: got wr=%b a=%h d=%h want wr=1 a=00020000 d=c3", mem_wr, mem_a, mem_dout);
        end
        tick(); tick();
        io_buffer_full_in = 1'b0;
    endtask

    task automatic test_flush_fetch();
        logic seen_valid;
        seen_valid = 1'b0;
        if_req = 1'b1; if_addr = 32'h1000;
        tick(); tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0; if_req = 1'b0;
        n_cmp++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL flush_rd_busy: got %b want 0", busy_out); end
        for (int i = 0; i < 8; i++) begin
            if (if_valid_out) seen_valid = 1'b1;
            tick();
        end
        n_cmp++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL flush_rd_valid: got %b want 0", seen_valid); end
        ld_req = 1'b1; ld_addr = 32'h2003; ld_type = 3'b000; flush_in = 1'b1;
        tick();
        ld_req = 1'b0; flush_in = 1'b0;
        n_cmp++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL flush_idle_grant: got busy %b want 0", busy_out); end
        tick();
    endtask

    task automatic test_flush_store();
        st_req = 1'b1; st_addr = 32'h200; st_type = 2'b10; st_data = 32'h11223344;
        tick();
        st_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            flush_in = (k == 1 || k == 2);
            n_cmp++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h200 + 32'(k), FL_BYTES[k]}) begin
                n_fail++; $display("FAIL flush_sw_byte[%0d]: got wr=%b a=%h d=%h want wr=1 a=%h d=%h",
                                   k, mem_wr, mem_a, mem_dout, 32'h200 + 32'(k), FL_BYTES[k]);
            end
            tick();
        end
        flush_in = 1'b0;
        n_cmp++; if (st_done_out !== 1'b1) begin n_fail++; $display("FAIL flush_sw_done: got %b want 1", st_done_out); end
        tick();
    endtask

    task automatic test_priority();
        int c_if, c_wr, c_sd, c_ld;
        logic [31:0] wa, lv;
        logic [7:0] wd;
        logic b6;
        c_if = 0; c_wr = 0; c_sd = 0; c_ld = 0; wa = '0; wd = '0; lv = '0; b6 = 1'b0;
        if_req = 1'b1; if_addr = 32'h1000;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (if_valid_out && c_if == 0) c_if = i;
            if (mem_wr && c_wr == 0) begin c_wr = i; wa = mem_a; wd = mem_dout; end
            if (st_done_out && c_sd == 0) c_sd = i;
            if (ld_valid_out && c_ld == 0) begin c_ld = i; lv = ld_value_out; end
            if (i == 6) b6 = busy_out;
            if (if_valid_out) if_req = 1'b0;
            if (ld_valid_out) ld_req = 1'b0;
            if (i == 1) begin ld_req = 1'b1; ld_addr = 32'h2008; ld_type = 3'b010; ld_dep = 6'd9; end
            if (i == 2) begin st_req = 1'b1; st_addr = 32'h300; st_type = 2'b00; st_data = 32'h00000077; end
            if (i == 3) st_req = 1'b0;
        end
        if_req = 1'b0; ld_req = 1'b0;
        n_cmp++; if (c_if !== 6) begin n_fail++; $display("FAIL prio_fetch_cycle: got %0d want 6", c_if); end
        n_cmp++; if (b6 !== 1'b1) begin n_fail++; $display("FAIL prio_busy_pending: got %b want 1", b6); end
        n_cmp++; if ({c_wr, wa, wd} !== {32'd7, 32'h300, 8'h77}) begin
            n_fail++; $display("FAIL prio_store: got cyc=%0d a=%h d=%h want cyc=7 a=00000300 d=77", c_wr, wa, wd);
        end
        n_cmp++; if (c_sd !== 8) begin n_fail++; $display("FAIL prio_st_done_cycle: got %0d want 8", c_sd); end
        n_cmp++; if ({c_ld, lv} !== {32'd14, 32'h12345678}) begin
            n_fail++; $display("FAIL prio_load: got cyc=%0d v=%h want cyc=14 v=12345678", c_ld, lv);
        end
        n_cmp++; if (ld_dep_out !== 6'd9) begin n_fail++; $display("FAIL prio_load_dep: got %0d want 9", ld_dep_out); end
    endtask

`ifdef MEM_ARB_RR_EN
    task automatic test_round_robin();
        int n;
        int order [3];
        n = 0; order = '{2, 2, 2};
        if_req = 1'b1; if_addr = 32'h1000;
        ld_req = 1'b1; ld_addr = 32'h2003; ld_type = 3'b100; ld_dep = 6'd3;
        for (int i = 1; i <= 40 && n < 3; i++) begin
            tick();
            if (if_valid_out) begin order[n] = 0; n++; end
            else if (ld_valid_out) begin order[n] = 1; n++; end
        end
        if_req = 1'b0; ld_req = 1'b0;
        // Last grant before this was a load, so fetch goes first.
        n_cmp++; if (order[0] !== 0) begin n_fail++; $display("FAIL rr_first: got %0d want 0", order[0]); end
        n_cmp++; if (order[1] !== 1) begin n_fail++; $display("FAIL rr_second: got %0d want 1", order[1]); end
        n_cmp++; if (order[2] !== 0) begin n_fail++; $display("FAIL rr_third: got %0d want 0", order[2]); end
        tick(); tick();
    endtask
`endif

    task automatic test_reset_mid();
        st_req = 1'b1; st_addr = 32'h400; st_type = 2'b10; st_data = 32'hCAFEF00D;
        tick();
        st_req = 1'b0;
        tick();
        #2;
        rst_n_in = 1'b0;
        #1;
        n_cmp++; if ({mem_wr, busy_out, mem_a} !== {1'b0, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL reset_mid: got wr=%b busy=%b a=%h want 0 0 0", mem_wr, busy_out, mem_a);
        end
        tick();
        rst_n_in = 1'b1;
        tick(); tick();
        n_cmp++; if ({mem_wr, st_done_out, busy_out} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid_after: got %b want 000", {mem_wr, st_done_out, busy_out});
        end
    endtask

    initial begin
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h00; ram[32'h1002] = 8'h50; ram[32'h1003] = 8'h00;
        ram[32'h2003] = 8'h80; ram[32'h2004] = 8'h34; ram[32'h2005] = 8'h92;
        ram[32'h2008] = 8'h78; ram[32'h2009] = 8'h56; ram[32'h200A] = 8'h34; ram[32'h200B] = 8'h12;

        test_reset();
        test_fetch();
        test_load_ext();
        test_rdy_freeze();
        test_store_word();
        test_io_store();
        test_flush_fetch();
        test_flush_store();
        test_priority();
`ifdef MEM_ARB_RR_EN
        test_round_robin();
`endif
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
